// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU, the OAM DMA controller and the shared memory bus.
// The master modport is the controller side; the slave modport is the surrounding system.
interface oam_dma_if;
   logic [15:0] cpu_mem_addr;
   logic [7:0]  cpu_mem_data_out;
   logic        cpu_mem_write_en;
   logic        cpu_mem_read_en;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_out;
   logic        mem_write_en;
   logic        mem_read_en;
   logic [7:0]  mem_data_in;
   logic        cpu_halt;
   logic        dma_busy;
   logic        dma_done;
   logic [7:0]  dma_page;

   modport master (
      input  cpu_mem_addr, cpu_mem_data_out, cpu_mem_write_en, cpu_mem_read_en, mem_data_in,
      output mem_addr, mem_data_out, mem_write_en, mem_read_en,
      output cpu_halt, dma_busy, dma_done, dma_page
   );

   modport slave (
      output cpu_mem_addr, cpu_mem_data_out, cpu_mem_write_en, cpu_mem_read_en, mem_data_in,
      input  mem_addr, mem_data_out, mem_write_en, mem_read_en,
      input  cpu_halt, dma_busy, dma_done, dma_page
   );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA: on a CPU write to the trigger register, halts the CPU and copies one source page
// byte-by-byte into the OAM data register, then returns the bus to the CPU.
module oam_dma_controller #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int unsigned READ_LATENCY  = 2,
   parameter int unsigned XFER_LEN      = 256
) (
   input logic       clk,
   input logic       rst,
   oam_dma_if.master bus
);

   typedef enum logic [2:0] {StIdle, StAlign, StRead, StWait, StWrite, StDone} state_e;

   localparam int unsigned WaitLastInt = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
   localparam logic [7:0]  WaitLast    = WaitLastInt[7:0];
   localparam int unsigned CntLastInt  = XFER_LEN - 1;
   localparam logic [7:0]  CntLast     = CntLastInt[7:0];

   state_e     state_q, state_d;
   logic       parity_q;
   logic       we_q;
   logic       extra_align_q, extra_align_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] wait_q, wait_d;
   logic [7:0] data_q, data_d;
   logic [7:0] page_q, page_d;

   logic        trigger;
   logic        busy;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_we;
   logic        dma_re;

   // Edge-qualified so a strobe held through the whole transfer cannot retrigger.
   assign trigger = bus.cpu_mem_write_en && (bus.cpu_mem_addr == DMA_REG_ADDR) && !we_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         parity_q      <= 1'b0;
         we_q          <= 1'b0;
         extra_align_q <= 1'b0;
         cnt_q         <= 8'd0;
         wait_q        <= 8'd0;
         data_q        <= 8'd0;
         page_q        <= 8'd0;
      end else begin
         state_q       <= state_d;
         parity_q      <= ~parity_q;
         we_q          <= bus.cpu_mem_write_en;
         extra_align_q <= extra_align_d;
         cnt_q         <= cnt_d;
         wait_q        <= wait_d;
         data_q        <= data_d;
         page_q        <= page_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      extra_align_d = extra_align_q;
      cnt_d         = cnt_q;
      wait_d        = wait_q;
      data_d        = data_q;
      page_d        = page_q;
      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               page_d        = bus.cpu_mem_data_out;
               cnt_d         = 8'd0;
               extra_align_d = parity_q;
               state_d       = StAlign;
            end
         end
         StAlign: begin
            if (extra_align_q) extra_align_d = 1'b0;
            else               state_d       = StRead;
         end
         StRead: begin
            if (READ_LATENCY == 1) begin
               data_d  = bus.mem_data_in;
               state_d = StWrite;
            end else begin
               wait_d  = 8'd0;
               state_d = StWait;
            end
         end
         StWait: begin
            if (wait_q == WaitLast) begin
               data_d  = bus.mem_data_in;
               state_d = StWrite;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StWrite: begin
            cnt_d   = cnt_q + 8'd1;
            state_d = (cnt_q == CntLast) ? StDone : StRead;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = (state_q != StIdle);
      dma_addr  = 16'h0000;
      dma_wdata = 8'h00;
      dma_we    = 1'b0;
      dma_re    = 1'b0;
      unique case (state_q)
         StRead: begin
            dma_addr = {page_q, cnt_q};
            dma_re   = 1'b1;
         end
         StWrite: begin
            dma_addr  = OAM_DATA_ADDR;
            dma_wdata = data_q;
            dma_we    = 1'b1;
         end
         default: ;
      endcase

      bus.mem_addr     = busy ? dma_addr  : bus.cpu_mem_addr;
      bus.mem_data_out = busy ? dma_wdata : bus.cpu_mem_data_out;
      bus.mem_write_en = busy ? dma_we    : bus.cpu_mem_write_en;
      bus.mem_read_en  = busy ? dma_re    : bus.cpu_mem_read_en;
      bus.cpu_halt     = busy;
      bus.dma_busy     = busy;
      bus.dma_done     = (state_q == StDone);
      bus.dma_page     = page_q;
   end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: default instance plus a READ_LATENCY=3, XFER_LEN=4 one.
module tb_oam_dma_controller;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   oam_dma_if a_if ();
   oam_dma_if b_if ();

   oam_dma_controller u_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   oam_dma_controller #(
      .READ_LATENCY (3),
      .XFER_LEN     (4)
   ) u_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   int checks = 0;
   int errors = 0;
   int cyc;

   logic [7:0] mem [65536];

   // Read data is valid only in the single cycle ending READ_LATENCY edges after the strobe.
   logic        a_v1 = 1'b0, b_v1 = 1'b0, b_v2 = 1'b0;
   logic [15:0] a_a1 = 16'h0, b_a1 = 16'h0, b_a2 = 16'h0;
   always @(posedge clk) begin
      a_v1 <= a_if.mem_read_en;
      a_a1 <= a_if.mem_addr;
      b_v1 <= b_if.mem_read_en;
      b_a1 <= b_if.mem_addr;
      b_v2 <= b_v1;
      b_a2 <= b_a1;
   end
   assign a_if.mem_data_in = a_v1 ? mem[a_a1] : 8'hEE;
   assign b_if.mem_data_in = b_v2 ? mem[b_a2] : 8'hEE;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic cpu_idle();
      a_if.cpu_mem_addr     = 16'h0000;
      a_if.cpu_mem_data_out = 8'h00;
      a_if.cpu_mem_write_en = 1'b0;
      a_if.cpu_mem_read_en  = 1'b0;
      b_if.cpu_mem_addr     = 16'h0000;
      b_if.cpu_mem_data_out = 8'h00;
      b_if.cpu_mem_write_en = 1'b0;
      b_if.cpu_mem_read_en  = 1'b0;
   endtask

   // Triggers a transfer on instance A at the requested parity and measures it until 3 idle
   // cycles follow the end of the busy window.
   task automatic run_a(input logic [7:0] page, input logic want_odd, input bit hold,
                        output int halt_n, output int done_n, output int rd_n,
                        output int wr_n, output int first_rd, output int bad_n);
      int  post;
      bit  seen;
      halt_n = 0; done_n = 0; rd_n = 0; wr_n = 0; bad_n = 0; first_rd = -1;
      post = 0; seen = 0;
      @(negedge clk);
      while (cyc[0] != want_odd) @(negedge clk);
      a_if.cpu_mem_addr     = 16'h4014;
      a_if.cpu_mem_data_out = page;
      a_if.cpu_mem_write_en = 1'b1;
      for (int k = 0; k < 900 && post < 3; k++) begin
         @(negedge clk);
         if (!hold) a_if.cpu_mem_write_en = 1'b0;
         #1;
         if (a_if.cpu_halt) halt_n++;
         if (a_if.dma_done) done_n++;
         if (a_if.dma_busy) seen = 1;
         else if (seen) post++;
         if (a_if.dma_busy && a_if.mem_read_en) begin
            if (first_rd < 0) first_rd = k;
            if (a_if.mem_addr !== {page, rd_n[7:0]}) bad_n++;
            rd_n++;
         end
         if (a_if.dma_busy && a_if.mem_write_en) begin
            if (a_if.mem_addr !== 16'h2004 || a_if.mem_data_out !== mem[{page, wr_n[7:0]}])
               bad_n++;
            wr_n++;
         end
      end
      a_if.cpu_mem_write_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_idle();
      a_if.cpu_mem_addr = 16'h1234;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (a_if.cpu_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", a_if.cpu_halt); end
      checks++; if (a_if.dma_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_if.dma_busy); end
      checks++; if (a_if.dma_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_if.dma_done); end
      checks++; if (a_if.dma_page !== 8'h00) begin errors++; $display("FAIL reset_page: got %h want 00", a_if.dma_page); end
      checks++; if (a_if.mem_addr !== 16'h1234) begin errors++; $display("FAIL reset_passthru: got %h want 1234", a_if.mem_addr); end
      @(negedge clk);
      rst = 1'b0;
      cpu_idle();
   endtask

   task automatic test_passthrough();
      @(negedge clk);
      a_if.cpu_mem_addr    = 16'h0123;
      a_if.cpu_mem_read_en = 1'b1;
      #1;
      checks++; if (a_if.mem_addr !== 16'h0123) begin errors++; $display("FAIL pt_rd_addr: got %h want 0123", a_if.mem_addr); end
      checks++; if (a_if.mem_read_en !== 1'b1 || a_if.mem_write_en !== 1'b0) begin errors++; $display("FAIL pt_rd_strobes: got re=%b we=%b want re=1 we=0", a_if.mem_read_en, a_if.mem_write_en); end
      checks++; if (a_if.cpu_halt !== 1'b0) begin errors++; $display("FAIL pt_halt: got %b want 0", a_if.cpu_halt); end
      @(negedge clk);
      a_if.cpu_mem_read_en  = 1'b0;
      a_if.cpu_mem_addr     = 16'h0200;
      a_if.cpu_mem_data_out = 8'h55;
      a_if.cpu_mem_write_en = 1'b1;
      #1;
      checks++; if (a_if.mem_addr !== 16'h0200 || a_if.mem_data_out !== 8'h55) begin errors++; $display("FAIL pt_wr: got %h/%h want 0200/55", a_if.mem_addr, a_if.mem_data_out); end
      checks++; if (a_if.mem_write_en !== 1'b1 || a_if.mem_read_en !== 1'b0) begin errors++; $display("FAIL pt_wr_strobes: got we=%b re=%b want we=1 re=0", a_if.mem_write_en, a_if.mem_read_en); end
      @(negedge clk);
      cpu_idle();
   endtask

   task automatic test_basic_dma();
      int h, d, r, w, f, b;
      run_a(8'h02, 1'b0, 1'b0, h, d, r, w, f, b);
      checks++; if (h != 770) begin errors++; $display("FAIL basic_halt_cycles: got %0d want 770", h); end
      checks++; if (d != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", d); end
      checks++; if (r != 256 || w != 256) begin errors++; $display("FAIL basic_counts: got rd=%0d wr=%0d want 256/256", r, w); end
      checks++; if (b != 0) begin errors++; $display("FAIL basic_addr_data: got %0d bad beats want 0", b); end
      checks++; if (f != 1) begin errors++; $display("FAIL basic_first_read: got cycle %0d want 1", f); end
      checks++; if (a_if.dma_page !== 8'h02) begin errors++; $display("FAIL basic_page: got %h want 02", a_if.dma_page); end
   endtask

   task automatic test_odd_align();
      int h, d, r, w, f, b;
      run_a(8'h02, 1'b1, 1'b0, h, d, r, w, f, b);
      checks++; if (h != 771) begin errors++; $display("FAIL odd_halt_cycles: got %0d want 771", h); end
      checks++; if (f != 2) begin errors++; $display("FAIL odd_first_read: got cycle %0d want 2", f); end
      checks++; if (d != 1 || w != 256 || b != 0) begin errors++; $display("FAIL odd_transfer: got done=%0d wr=%0d bad=%0d want 1/256/0", d, w, b); end
   endtask

   task automatic test_held_strobe();
      int h, d, r, w, f, b;
      bit finished;
      run_a(8'h02, 1'b0, 1'b1, h, d, r, w, f, b);
      checks++; if (h != 770 || d != 1) begin errors++; $display("FAIL held_single: got halt=%0d done=%0d want 770/1", h, d); end
      checks++; if (w != 256 || b != 0) begin errors++; $display("FAIL held_data: got wr=%0d bad=%0d want 256/0", w, b); end
      @(negedge clk);
      a_if.cpu_mem_addr     = 16'h4014;
      a_if.cpu_mem_data_out = 8'h02;
      a_if.cpu_mem_write_en = 1'b1;
      @(negedge clk);
      a_if.cpu_mem_write_en = 1'b0;
      #1;
      checks++; if (a_if.dma_busy !== 1'b1) begin errors++; $display("FAIL held_reraise: got busy=%b want 1", a_if.dma_busy); end
      finished = 0;
      for (int k = 0; k < 900 && !finished; k++) begin
         @(negedge clk);
         #1;
         if (!a_if.dma_busy) finished = 1;
      end
      checks++; if (!finished) begin errors++; $display("FAIL held_reraise_end: got busy=1 after 900 cycles want 0"); end
   endtask

   task automatic test_reset_mid();
      int h, d, r, w, f, b;
      int wr;
      wr = 0;
      @(negedge clk);
      a_if.cpu_mem_addr     = 16'h4014;
      a_if.cpu_mem_data_out = 8'h02;
      a_if.cpu_mem_write_en = 1'b1;
      for (int k = 0; k < 900 && wr < 101; k++) begin
         @(negedge clk);
         a_if.cpu_mem_write_en = 1'b0;
         #1;
         if (a_if.dma_busy && a_if.mem_write_en) wr++;
      end
      checks++; if (wr != 101) begin errors++; $display("FAIL rstmid_progress: got %0d writes want 101", wr); end
      a_if.cpu_mem_addr    = 16'h0456;
      a_if.cpu_mem_read_en = 1'b1;
      rst = 1'b1;
      #1;
      checks++; if (a_if.cpu_halt !== 1'b0 || a_if.dma_busy !== 1'b0) begin errors++; $display("FAIL rstmid_release: got halt=%b busy=%b want 0/0", a_if.cpu_halt, a_if.dma_busy); end
      checks++; if (a_if.mem_addr !== 16'h0456 || a_if.mem_read_en !== 1'b1) begin errors++; $display("FAIL rstmid_passthru: got %h re=%b want 0456 re=1", a_if.mem_addr, a_if.mem_read_en); end
      @(negedge clk);
      rst = 1'b0;
      cpu_idle();
      run_a(8'h02, 1'b0, 1'b0, h, d, r, w, f, b);
      checks++; if (h != 770 || w != 256 || b != 0) begin errors++; $display("FAIL rstmid_restart: got halt=%0d wr=%0d bad=%0d want 770/256/0", h, w, b); end
   endtask

   task automatic test_param_sweep();
      int halt_n, done_n, rd_n, wr_n, bad_n, last_rd, post;
      bit seen;
      halt_n = 0; done_n = 0; rd_n = 0; wr_n = 0; bad_n = 0; last_rd = 0; post = 0; seen = 0;
      @(negedge clk);
      while (cyc[0] != 1'b0) @(negedge clk);
      b_if.cpu_mem_addr     = 16'h4014;
      b_if.cpu_mem_data_out = 8'h07;
      b_if.cpu_mem_write_en = 1'b1;
      for (int k = 0; k < 60 && post < 3; k++) begin
         @(negedge clk);
         b_if.cpu_mem_write_en = 1'b0;
         #1;
         if (b_if.cpu_halt) halt_n++;
         if (b_if.dma_done) done_n++;
         if (b_if.dma_busy) seen = 1;
         else if (seen) post++;
         if (b_if.dma_busy && b_if.mem_read_en) begin
            if (b_if.mem_addr !== {8'h07, rd_n[7:0]}) bad_n++;
            last_rd = k;
            rd_n++;
         end
         if (b_if.dma_busy && b_if.mem_write_en) begin
            if (b_if.mem_addr !== 16'h2004 || b_if.mem_data_out !== mem[{8'h07, wr_n[7:0]}]
                || (k - last_rd) != 3) bad_n++;
            wr_n++;
         end
      end
      checks++; if (halt_n != 18) begin errors++; $display("FAIL sweep_halt_cycles: got %0d want 18", halt_n); end
      checks++; if (rd_n != 4 || wr_n != 4 || done_n != 1) begin errors++; $display("FAIL sweep_counts: got rd=%0d wr=%0d done=%0d want 4/4/1", rd_n, wr_n, done_n); end
      checks++; if (bad_n != 0) begin errors++; $display("FAIL sweep_data_timing: got %0d bad beats want 0", bad_n); end
      checks++; if (b_if.dma_page !== 8'h07) begin errors++; $display("FAIL sweep_page: got %h want 07", b_if.dma_page); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
         mem[16'h0700 + i] = 8'(i * 7 + 3);
      end
      test_reset();
      test_passthrough();
      test_basic_dma();
      test_odd_align();
      test_held_strobe();
      test_reset_mid();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
